// File: rtl/fpmath_defs.sv
// Format constants and operand classification helpers shared by the fpmath units.
// Every unit treats exponent-zero operands as signed zero (no subnormal support).
package fpmath_defs;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]      QNAN    = 32'h7FC00000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    function automatic logic is_nan(input fp32_t x);
        return (x.exp == EXP_MAX) && (x.frac != '0);
    endfunction

    function automatic logic is_inf(input fp32_t x);
        return (x.exp == EXP_MAX) && (x.frac == '0);
    endfunction

    // Subnormals fold into zero here, so callers never see them as finite nonzero.
    function automatic logic is_zero(input fp32_t x);
        return x.exp == '0;
    endfunction

endpackage

// File: rtl/fpmul_round.sv
// Normalises the 48-bit mantissa product, rounds to nearest-even and applies
// the overflow/underflow range checks, producing the final finite-path result.
module fpmul_round
    import fpmath_defs::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp_in,
    input  logic [47:0]       prod,
    output logic [31:0]       res,
    output logic              range_err
);

    logic [23:0]       mant;
    logic              guard;
    logic              rnd;
    logic              sticky;
    logic              round_up;
    logic [24:0]       sum;
    logic [22:0]       frac;
    logic signed [9:0] exp_n;
    logic signed [9:0] exp_r;

    always_comb begin
        mant   = prod[46:23];
        guard  = prod[22];
        rnd    = prod[21];
        sticky = |prod[20:0];
        exp_n  = exp_in;
        if (prod[47]) begin
            mant   = prod[47:24];
            guard  = prod[23];
            rnd    = prod[22];
            sticky = |prod[21:0];
            exp_n  = exp_in + 10'sd1;
        end

        round_up = guard & (rnd | sticky | mant[0]);
        sum      = {1'b0, mant} + {24'd0, round_up};

        // A carry out of the mantissa leaves 1.000..0, one binade higher.
        frac  = sum[22:0];
        exp_r = exp_n;
        if (sum[24]) begin
            frac  = sum[23:1];
            exp_r = exp_n + 10'sd1;
        end

        res       = {sign, exp_r[EXP_W-1:0], frac};
        range_err = 1'b0;
        if (exp_r >= 10'sd255) begin
            res       = {sign, EXP_MAX, {FRAC_W{1'b0}}};
            range_err = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            res       = {sign, 31'd0};
            range_err = 1'b1;
        end
    end

endmodule

// File: rtl/fpmul.sv
// binary32 multiplier: special-case detection and the mantissa multiply are
// combinational; the selected result and range flag are registered once.
module fpmul
    import fpmath_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c,
    output logic        over_mul_under
);

    localparam logic signed [9:0] BIAS10 = 10'(BIAS);

    fp32_t             fa;
    fp32_t             fb;
    logic              sign;
    logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [47:0]       prod;
    logic signed [9:0] exp_sum;
    logic [31:0]       fin_res;
    logic              fin_err;
    logic [31:0]       c_d;
    logic              flag_d;

    assign fa   = a;
    assign fb   = b;
    assign sign = fa.sign ^ fb.sign;

    assign nan_a  = is_nan(fa);
    assign nan_b  = is_nan(fb);
    assign inf_a  = is_inf(fa);
    assign inf_b  = is_inf(fb);
    assign zero_a = is_zero(fa);
    assign zero_b = is_zero(fb);

    assign prod    = {24'd0, 1'b1, fa.frac} * {24'd0, 1'b1, fb.frac};
    assign exp_sum = $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp}) - BIAS10;

    fpmul_round u_round (
        .sign      (sign),
        .exp_in    (exp_sum),
        .prod      (prod),
        .res       (fin_res),
        .range_err (fin_err)
    );

    // NaN outranks inf*0, which outranks plain infinity and zero.
    always_comb begin
        c_d    = fin_res;
        flag_d = fin_err;
        if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) begin
            c_d    = QNAN;
            flag_d = 1'b0;
        end else if (inf_a || inf_b) begin
            c_d    = {sign, EXP_MAX, {FRAC_W{1'b0}}};
            flag_d = 1'b0;
        end else if (zero_a || zero_b) begin
            c_d    = {sign, 31'd0};
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c              <= 32'd0;
            over_mul_under <= 1'b0;
        end else begin
            c              <= c_d;
            over_mul_under <= flag_d;
        end
    end

endmodule

// File: tb/tb_fpmul.sv
// Directed-vector bench for fpmul: table of hand-computed products applied in
// both operand orders, plus reset and output-stability sequences.
module tb_fpmul;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a   = 32'd0;
    logic [31:0] b   = 32'd0;
    logic [31:0] c;
    logic        over_mul_under;

    fpmul dut (
        .clk            (clk),
        .rst            (rst),
        .a              (a),
        .b              (b),
        .c              (c),
        .over_mul_under (over_mul_under)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        f;
    } vec_t;

    vec_t        vecs[$];
    logic [32:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got flag=%0b c=%08h, expected flag=%0b c=%08h",
                     name, got[32], got[31:0], want[32], want[31:0]);
        end
    endtask

    task automatic add(input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] vc, input logic vf);
        vec_t v;
        v.a = va; v.b = vb; v.c = vc; v.f = vf;
        vecs.push_back(v);
    endtask

    // Drives one operand pair, then checks the registered result one edge later.
    task automatic drive(input string name, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] vc, input logic vf);
        logic [32:0] want;
        @(negedge clk);
        a = va;
        b = vb;
        exp_q.push_back({vf, vc});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            want = exp_q.pop_front();
            check(name, {over_mul_under, c}, want);
        end
    endtask

    initial begin
        // Basic products
        add(32'h3F800000, 32'h40000000, 32'h40000000, 1'b0);
        add(32'h40400000, 32'hC0000000, 32'hC0C00000, 1'b0);
        add(32'h41200000, 32'h42C80000, 32'h447A0000, 1'b0);
        add(32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0);
        add(32'h7F000000, 32'h3F000000, 32'h7E800000, 1'b0);
        // Rounding: inexact, tie-up to even, tie-down to even, near-one
        add(32'h3F800001, 32'h3F800001, 32'h3F800002, 1'b0);
        add(32'h3F800001, 32'h40400000, 32'h40400002, 1'b0);
        add(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 1'b0);
        add(32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 1'b0);
        // Overflow / underflow and the boundaries around them
        add(32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1);
        add(32'hFF000000, 32'h7F000000, 32'hFF800000, 1'b1);
        add(32'h7F7FFFFF, 32'h3F800001, 32'h7F800000, 1'b1);
        add(32'h00800000, 32'h00800000, 32'h00000000, 1'b1);
        add(32'h80800000, 32'h00800000, 32'h80000000, 1'b1);
        add(32'h00800000, 32'h3F7FFFFF, 32'h00000000, 1'b1);
        add(32'h00800000, 32'h3F800000, 32'h00800000, 1'b0);
        add(32'h00800001, 32'hBF800000, 32'h80800001, 1'b0);
        // Specials
        add(32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0);
        add(32'h7F800000, 32'h00400000, 32'h7FC00000, 1'b0);
        add(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0);
        add(32'hFF800001, 32'h7F800000, 32'h7FC00000, 1'b0);
        add(32'h7F800000, 32'hBF800000, 32'hFF800000, 1'b0);
        add(32'h00000001, 32'h7F000000, 32'h00000000, 1'b0);
        add(32'h80000000, 32'h3F800000, 32'h80000000, 1'b0);

        // Reset state while rst held
        #3;
        check("reset_hold", {over_mul_under, c}, 33'd0);
        @(posedge clk);
        #1;
        check("reset_edge", {over_mul_under, c}, 33'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors in both operand orders, back to back
        foreach (vecs[i]) begin
            drive($sformatf("vec%0d_ab", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].f);
            drive($sformatf("vec%0d_ba", i), vecs[i].b, vecs[i].a, vecs[i].c, vecs[i].f);
        end

        // Mid-stream reset: asynchronous clear, held across an edge
        drive("pre_reset", 32'h41200000, 32'h42C80000, 32'h447A0000, 1'b0);
        #2;
        a   = 32'h40000000;
        b   = 32'h40400000;
        rst = 1'b1;
        #1;
        check("async_reset", {over_mul_under, c}, 33'd0);
        @(posedge clk);
        #1;
        check("reset_held_edge", {over_mul_under, c}, 33'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("released_pre_edge", {over_mul_under, c}, 33'd0);
        @(posedge clk);
        #1;
        check("first_after_release", {over_mul_under, c}, {1'b0, 32'h40C00000});

        // Input change between edges must not reach the outputs
        #2;
        a = 32'h7F000000;
        b = 32'h40000000;
        #1;
        check("no_comb_path", {over_mul_under, c}, {1'b0, 32'h40C00000});
        @(posedge clk);
        #1;
        check("after_change_edge", {over_mul_under, c}, {1'b1, 32'h7F800000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
